// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the picoMIPS instruction fetch stage:
// default field widths, instruction field positions and the FSM state encoding.
package instr_fetch_pkg;

    localparam int DEF_P_SIZE = 6;
    localparam int DEF_O_SIZE = 6;
    localparam int DEF_D_SIZE = 8;
    localparam int DEF_I_SIZE = DEF_O_SIZE + DEF_D_SIZE;

    // Opcode sits directly above the immediate in the instruction word.
    localparam int IMM_LSB = 0;
    localparam int OPC_LSB = DEF_D_SIZE;
    localparam int OPC_MSB = DEF_I_SIZE - 1;

    localparam logic [7:0] WAIT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    function automatic logic [7:0] wait_next(input logic [7:0] cur);
        return (cur == WAIT_MAX) ? cur : cur + 8'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-ROM/decoder signal bundle; master is the fetch unit, slave is the
// ROM plus decoder side.
interface instr_fetch_if #(
    parameter int P_SIZE = 6,
    parameter int O_SIZE = 6,
    parameter int D_SIZE = 8
) ();
    localparam int I_SIZE = O_SIZE + D_SIZE;

    logic              PCincr;
    logic              branch;
    logic [I_SIZE-1:0] prog_data;
    logic [P_SIZE-1:0] prog_addr;
    logic [O_SIZE-1:0] opcode;
    logic [D_SIZE-1:0] imm_field;
    logic              instr_valid;
    logic              halted;
    logic [7:0]        wait_cycles;

    modport master (
        input  PCincr, branch, prog_data,
        output prog_addr, opcode, imm_field, instr_valid, halted, wait_cycles
    );

    modport slave (
        output PCincr, branch, prog_data,
        input  prog_addr, opcode, imm_field, instr_valid, halted, wait_cycles
    );
endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: holds, increments, or adds a sign-extended relative offset,
// all modulo 2^P_SIZE.
module instr_fetch_pc_reg #(
    parameter int P_SIZE = 6,
    parameter int D_SIZE = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              i_adv,
    input  logic              i_branch,
    input  logic [D_SIZE-1:0] i_offset,
    output logic [P_SIZE-1:0] o_pc
);
    logic [P_SIZE-1:0] r_pc;
    logic [P_SIZE-1:0] w_offset;

    // Sign-extends when P_SIZE > D_SIZE, keeps the low bits otherwise.
    assign w_offset = P_SIZE'($signed(i_offset));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_pc <= '0;
        end else if (i_adv) begin
            if (i_branch) r_pc <= r_pc + w_offset;
            else          r_pc <= r_pc + P_SIZE'(1);
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/instr_fetch.sv
// picoMIPS fetch stage: sequences ROM reads into the instruction register,
// advances/branches the PC on PCincr and stops on the self-branch halt idiom.
//
//   state  | meaning
//   IDLE   | first cycle after reset, PC=0 already on the ROM address
//   FETCH  | ROM word for PC arriving; captured into IR at the next edge
//   EXEC   | IR valid, decoder working; PCincr/branch sampled each edge
//   HALT   | self-branch executed; everything frozen until reset
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int P_SIZE = DEF_P_SIZE,
    parameter int O_SIZE = DEF_O_SIZE,
    parameter int D_SIZE = DEF_D_SIZE
) (
    input  logic          clk,
    input  logic          n_reset,
    instr_fetch_if.master bus
);
    localparam int I_SIZE = O_SIZE + D_SIZE;

    state_t            r_state;
    logic [I_SIZE-1:0] r_ir;
    logic              r_instr_valid;
    logic              r_halted;
    logic [7:0]        r_wait;

    logic [P_SIZE-1:0] w_pc;
    logic [D_SIZE-1:0] w_imm;
    logic              w_exec_step;
    logic              w_self_branch;
    logic              w_pc_adv;

    assign w_imm         = r_ir[D_SIZE-1:0];
    assign w_exec_step   = (r_state == ST_EXEC) && bus.PCincr;
    assign w_self_branch = bus.branch && (w_imm == '0);
    assign w_pc_adv      = w_exec_step && !w_self_branch;

    instr_fetch_pc_reg #(
        .P_SIZE (P_SIZE),
        .D_SIZE (D_SIZE)
    ) u_pc_reg (
        .clk      (clk),
        .n_reset  (n_reset),
        .i_adv    (w_pc_adv),
        .i_branch (bus.branch),
        .i_offset (w_imm),
        .o_pc     (w_pc)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= ST_IDLE;
            r_ir          <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_wait        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state       <= ST_FETCH;
                    r_instr_valid <= 1'b0;
                end
                ST_FETCH: begin
                    r_ir          <= bus.prog_data;
                    r_state       <= ST_EXEC;
                    r_instr_valid <= 1'b1;
                end
                ST_EXEC: begin
                    if (!bus.PCincr) begin
                        r_wait <= wait_next(r_wait);
                    end else if (w_self_branch) begin
                        r_state       <= ST_HALT;
                        r_halted      <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end else begin
                        r_wait        <= '0;
                        r_state       <= ST_FETCH;
                        r_instr_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prog_addr   = w_pc;
    assign bus.opcode      = r_ir[I_SIZE-1:D_SIZE];
    assign bus.imm_field   = w_imm;
    assign bus.instr_valid = r_instr_valid;
    assign bus.halted      = r_halted;
    assign bus.wait_cycles = r_wait;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: small ROM model, hand-computed expectations
// for advance, hold, branch wrap, halt and asynchronous reset.
module tb_instr_fetch;
    logic clk     = 1'b0;
    logic n_reset = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    logic [13:0] rom [0:63];

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // ROM registers the address on the falling edge, so the word for the
    // current PC is stable before the FETCH->EXEC rising edge.
    always @(negedge clk) bus.prog_data <= rom[bus.prog_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_addr"},  32'(bus.prog_addr),   32'h0);
        chk({tag, "_opc"},   32'(bus.opcode),      32'h0);
        chk({tag, "_imm"},   32'(bus.imm_field),   32'h0);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
        chk({tag, "_halt"},  32'(bus.halted),      32'h0);
        chk({tag, "_wait"},  32'(bus.wait_cycles), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 14'h3F01;
        rom[0]  = 14'h0205;
        rom[1]  = 14'h0C11;
        rom[2]  = 14'h08FB;
        rom[5]  = 14'h0802;
        rom[7]  = 14'h0800;
        rom[61] = 14'h0802;
        bus.PCincr = 1'b1;
        bus.branch = 1'b0;

        #2 chk_rst("por");
        @(negedge clk) n_reset = 1'b1;

        step(); chk("f0_valid", 32'(bus.instr_valid), 32'h0);
        chk("f0_addr", 32'(bus.prog_addr), 32'h0);
        step(); chk("e0_valid", 32'(bus.instr_valid), 32'h1);
        chk("e0_opc", 32'(bus.opcode), 32'h02);
        chk("e0_imm", 32'(bus.imm_field), 32'h05);
        step(); chk("f1_addr", 32'(bus.prog_addr), 32'h1);
        chk("f1_valid", 32'(bus.instr_valid), 32'h0);

        bus.PCincr = 1'b0;
        step(); chk("e1_opc", 32'(bus.opcode), 32'h0C);
        chk("e1_imm", 32'(bus.imm_field), 32'h11);
        step(10);
        chk("hold_wait", 32'(bus.wait_cycles), 32'd10);
        chk("hold_addr", 32'(bus.prog_addr), 32'h1);
        chk("hold_valid", 32'(bus.instr_valid), 32'h1);
        bus.PCincr = 1'b1;
        step(); chk("adv_wait", 32'(bus.wait_cycles), 32'h0);
        chk("adv_addr", 32'(bus.prog_addr), 32'h2);

        step(); chk("e2_imm", 32'(bus.imm_field), 32'hFB);
        bus.branch = 1'b1;
        step(); chk("br_neg_addr", 32'(bus.prog_addr), 32'd61);
        step(); step(); chk("br_pos_addr", 32'(bus.prog_addr), 32'd63);
        bus.branch = 1'b0;
        step(); step(); chk("wrap_addr", 32'(bus.prog_addr), 32'd0);

        step(); bus.branch = 1'b1;
        step(); chk("br5_addr", 32'(bus.prog_addr), 32'd5);
        step(); step(); chk("br7_addr", 32'(bus.prog_addr), 32'd7);
        step(); chk("e7_valid", 32'(bus.instr_valid), 32'h1);
        chk("e7_halt", 32'(bus.halted), 32'h0);
        step();
        chk("halt_flag", 32'(bus.halted), 32'h1);
        chk("halt_valid", 32'(bus.instr_valid), 32'h0);
        chk("halt_addr", 32'(bus.prog_addr), 32'd7);
        for (int i = 0; i < 20; i++) begin
            bus.PCincr = i[0];
            bus.branch = i[1];
            step();
            chk("halt_hold_addr", 32'(bus.prog_addr), 32'd7);
            chk("halt_hold_valid", 32'(bus.instr_valid), 32'h0);
        end
        chk("halt_hold_flag", 32'(bus.halted), 32'h1);

        #2 n_reset = 1'b0;
        #1 chk_rst("rst_halt");
        bus.PCincr = 1'b1;
        bus.branch = 1'b0;
        @(negedge clk) n_reset = 1'b1;
        step(); step();
        chk("rs1_opc", 32'(bus.opcode), 32'h02);
        chk("rs1_addr", 32'(bus.prog_addr), 32'h0);
        chk("rs1_valid", 32'(bus.instr_valid), 32'h1);
        step(); chk("rs1_f1_addr", 32'(bus.prog_addr), 32'h1);

        #2 n_reset = 1'b0;
        #1 chk_rst("rst_fetch");
        @(negedge clk) n_reset = 1'b1;
        step(); step();
        chk("rs2_opc", 32'(bus.opcode), 32'h02);
        chk("rs2_addr", 32'(bus.prog_addr), 32'h0);
        chk("rs2_valid", 32'(bus.instr_valid), 32'h1);

        bus.PCincr = 1'b0;
        step(254); chk("sat_254", 32'(bus.wait_cycles), 32'd254);
        step(1);   chk("sat_255", 32'(bus.wait_cycles), 32'd255);
        step(45);  chk("sat_300", 32'(bus.wait_cycles), 32'd255);
        chk("sat_addr", 32'(bus.prog_addr), 32'h0);
        chk("sat_valid", 32'(bus.instr_valid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
